// File: rtl/pmod_io_bridge_if.sv
// PMOD host side and core side signal bundle for pmod_io_bridge.
// The bridge takes the slave view; the host/core environment takes the master view.
interface pmod_io_bridge_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] pmod_data_i;
  logic              pmod_tgl_i;
  logic              pmod_ack_i;
  logic [DATA_W-1:0] pmod_data_o;
  logic              pmod_req_o;
  logic [DATA_W-1:0] core_data_o;
  logic              core_valid_o;
  logic [DATA_W-1:0] core_data_i;
  logic              core_valid_i;
  logic              core_ready_o;

  modport slave (
    input  pmod_data_i, pmod_tgl_i, pmod_ack_i, core_data_i, core_valid_i,
    output pmod_data_o, pmod_req_o, core_data_o, core_valid_o, core_ready_o
  );

  modport master (
    output pmod_data_i, pmod_tgl_i, pmod_ack_i, core_data_i, core_valid_i,
    input  pmod_data_o, pmod_req_o, core_data_o, core_valid_o, core_ready_o
  );
endinterface

// File: rtl/pmod_io_bridge.sv
// PMOD-to-core bridge: synchronised toggle-strobe receive path, outbound FIFO drained
// to the host over a 4-phase req/ack handshake, with loopback and pattern self-test modes.
module pmod_io_bridge #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    mode_i,
  pmod_io_bridge_if.slave               bus,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o,
  output logic [CNT_W-1:0]              byte_cnt_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StRel} state_t;

  logic [SYNC_STAGES-1:0]             tgl_sync_q, ack_sync_q;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] data_sync_q;
  logic                               tgl_prev_q;
  logic                               tgl_s, ack_s, rx_evt;
  logic [DATA_W-1:0]                  data_s;

  logic [DATA_W-1:0] rx_data_q;
  logic              core_valid_q;
  logic              ready_en_q;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q, level;
  logic              full, empty, push, pop, drop;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] pat_q;
  logic              overflow_q;

  state_t            state_q;
  logic              req_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CNT_W-1:0]  byte_cnt_q;

  assign tgl_s  = tgl_sync_q[SYNC_STAGES-1];
  assign ack_s  = ack_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign rx_evt = tgl_s ^ tgl_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgl_sync_q   <= '0;
      ack_sync_q   <= '0;
      data_sync_q  <= '0;
      tgl_prev_q   <= 1'b0;
      rx_data_q    <= '0;
      core_valid_q <= 1'b0;
      ready_en_q   <= 1'b0;
    end else begin
      tgl_sync_q   <= {tgl_sync_q[SYNC_STAGES-2:0], bus.pmod_tgl_i};
      ack_sync_q   <= {ack_sync_q[SYNC_STAGES-2:0], bus.pmod_ack_i};
      data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], bus.pmod_data_i};
      tgl_prev_q   <= tgl_s;
      core_valid_q <= rx_evt & (mode_i == 2'b00);
      ready_en_q   <= 1'b1;
      if (rx_evt) rx_data_q <= data_s;
    end
  end

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == (AW+1)'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign pop   = (state_q == StIdle) & ~empty;

  always_comb begin
    push      = 1'b0;
    drop      = 1'b0;
    push_data = data_s;
    unique case (mode_i)
      2'b00: begin
        push      = bus.core_valid_i & ~full;
        push_data = bus.core_data_i;
      end
      2'b01: begin
        push = rx_evt & ~full;
        drop = rx_evt & full;
      end
      2'b10: begin
        push      = ~full;
        push_data = pat_q;
      end
      default: ;
    endcase
  end

  // Storage is left unreset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pat_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && mode_i == 2'b10) pat_q <= pat_q + 1'b1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      out_data_q <= '0;
      byte_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: if (!empty) begin
          out_data_q <= mem_q[rd_ptr_q[AW-1:0]];
          req_q      <= 1'b1;
          state_q    <= StReq;
        end
        StReq: if (ack_s) begin
          req_q      <= 1'b0;
          byte_cnt_q <= byte_cnt_q + 1'b1;
          state_q    <= StRel;
        end
        StRel: if (!ack_s) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pmod_data_o  = out_data_q;
  assign bus.pmod_req_o   = req_q;
  assign bus.core_data_o  = rx_data_q;
  assign bus.core_valid_o = core_valid_q;
  // Held low through reset so every output reads 0 while rst_n is asserted.
  assign bus.core_ready_o = ready_en_q & ~full & (mode_i == 2'b00);
  assign level_o          = level;
  assign overflow_o       = overflow_q;
  assign byte_cnt_o       = byte_cnt_q;
endmodule

// File: tb/tb_pmod_io_bridge.sv
// Randomised self-checking bench for pmod_io_bridge against a queue-based reference model.
module tb_pmod_io_bridge;
  localparam int unsigned DW = 8;
  localparam int unsigned SS = 2;
  localparam int unsigned FD = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [3:0]    level;
  logic          ovf;
  logic [CW-1:0] bcnt;

  pmod_io_bridge_if #(.DATA_W(DW)) bus ();

  pmod_io_bridge #(
    .DATA_W(DW), .SYNC_STAGES(SS), .FIFO_DEPTH(FD), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode), .bus(bus),
    .level_o(level), .overflow_o(ovf), .byte_cnt_o(bcnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q[$];
  bit            pat_chk = 1'b0;
  int            n_pat = 0;
  bit            ack_en = 1'b0;
  int            ack_dly = 0;
  int            hs = 0;
  logic          prev_req = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          tgl_v = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Outbound monitor: every new request must carry the next byte the model expects.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pmod_req_o && !prev_req) begin
        if (pat_chk) begin
          check("pat_data", 32'(bus.pmod_data_o), 32'(n_pat % 256));
          n_pat++;
        end else begin
          check("out_pending", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("out_data", 32'(bus.pmod_data_o), 32'(exp_q.pop_front()));
        end
      end else if (bus.pmod_req_o && prev_req) begin
        check("out_hold", 32'(bus.pmod_data_o), 32'(prev_data));
      end
    end
    prev_req  = bus.pmod_req_o;
    prev_data = bus.pmod_data_o;
  end

  // Host 4-phase responder.
  initial begin
    forever begin
      @(negedge clk);
      if (ack_en && rst_n && bus.pmod_req_o && !bus.pmod_ack_i) begin
        repeat (ack_dly) @(negedge clk);
        bus.pmod_ack_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (!bus.pmod_req_o) break;
        end
        bus.pmod_ack_i = 1'b0;
        hs++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic core_cycle(input bit v, input logic [DW-1:0] d, output bit took);
    bus.core_valid_i = v;
    bus.core_data_i  = d;
    #1;
    took = v && bus.core_ready_o;
    if (took) exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic host_toggle(input logic [DW-1:0] d);
    bus.pmod_data_i = d;
    @(negedge clk);
    tgl_v = ~tgl_v;
    bus.pmod_tgl_i = tgl_v;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 4000; i++) begin
      if (exp_q.size() == 0 && level == 0 && !bus.pmod_req_o && !bus.pmod_ack_i) break;
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check({tag, "_q"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_lvl"}, 32'(level), 32'd0);
  endtask

  initial begin
    bit            took;
    int            acc, pulses, at, h0;
    bit            exp_ovf;
    logic [DW-1:0] d;

    bus.pmod_data_i = '0; bus.pmod_tgl_i = 1'b0; bus.pmod_ack_i = 1'b0;
    bus.core_data_i = '0; bus.core_valid_i = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_req", 32'(bus.pmod_req_o), 32'd0);
    check("rst_pdata", 32'(bus.pmod_data_o), 32'd0);
    check("rst_cvalid", 32'(bus.core_valid_o), 32'd0);
    check("rst_cdata", 32'(bus.core_data_o), 32'd0);
    check("rst_ready", 32'(bus.core_ready_o), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_bcnt", 32'(bcnt), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal receive: one pulse, SS+1 cycles after the toggle, none while held.
    for (int r = 0; r < 6; r++) begin
      d = (r == 0) ? 8'hA5 : DW'($urandom);
      host_toggle(d);
      pulses = 0; at = 0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (bus.core_valid_o) begin
          pulses++; at = k;
          check("rx_data", 32'(bus.core_data_o), 32'(d));
        end
      end
      check("rx_pulses", 32'(pulses), 32'd1);
      check("rx_latency", 32'(at), 32'(SS + 1));
    end

    // Normal send with ack delayed 3 cycles.
    ack_dly = 3; ack_en = 1'b1;
    core_cycle(1'b1, 8'h11, took);
    core_cycle(1'b1, 8'h22, took);
    core_cycle(1'b1, 8'h33, took);
    core_cycle(1'b0, 8'h00, took);
    wait_drain("t2");
    check("t2_bcnt", 32'(bcnt), 32'(hs % 16));
    check("t2_hs", 32'(hs), 32'd3);

    // Full FIFO with ack held low: one byte in flight plus FD stored.
    ack_en = 1'b0; acc = 0;
    for (int i = 0; i < 20; i++) begin
      core_cycle(1'b1, DW'($urandom), took);
      acc += int'(took);
    end
    check("t3_acc", 32'(acc), 32'(FD + 1));
    check("t3_level", 32'(level), 32'(FD));
    check("t3_ready", 32'(bus.core_ready_o), 32'd0);
    check("t3_req", 32'(bus.pmod_req_o), 32'd1);
    ack_dly = 0; h0 = hs; ack_en = 1'b1; acc = 0;
    for (int i = 0; i < 20; i++) begin
      core_cycle(1'b1, DW'($urandom), took);
      acc += int'(took);
      if (hs != h0) ack_en = 1'b0;
    end
    check("t3_refill", 32'(acc), 32'd1);
    check("t3_level2", 32'(level), 32'(FD));
    check("t3_ready2", 32'(bus.core_ready_o), 32'd0);
    core_cycle(1'b0, 8'h00, took);
    ack_dly = int'($urandom_range(0, 3)); ack_en = 1'b1;
    wait_drain("t3");
    check("t3_bcnt", 32'(bcnt), 32'(hs % 16));

    // Loopback overflow with ack held low.
    ack_en = 1'b0; mode = 2'b01; acc = 0; exp_ovf = 1'b0;
    @(negedge clk);
    check("t4_ready", 32'(bus.core_ready_o), 32'd0);
    check("t4_ovf0", 32'(ovf), 32'd0);
    for (int t = 0; t < 10; t++) begin
      d = DW'($urandom);
      host_toggle(d);
      if (acc < FD + 1) begin
        exp_q.push_back(d);
        acc++;
      end else begin
        exp_ovf = 1'b1;
      end
      repeat (SS + 3) @(negedge clk);
    end
    check("t4_ovf", 32'(ovf), 32'(exp_ovf));
    check("t4_level", 32'(level), 32'(FD));
    ack_dly = int'($urandom_range(0, 3)); ack_en = 1'b1;
    wait_drain("t4");
    mode = 2'b11;
    check("t4_bcnt", 32'(bcnt), 32'(hs % 16));
    check("t4_ovf_sticky", 32'(ovf), 32'(exp_ovf));

    // Pattern mode: sequence wraps past FF, byte counter wraps at 2^CW.
    pat_chk = 1'b1; n_pat = 0; ack_dly = 0;
    mode = 2'b10;
    for (int i = 0; i < 10000; i++) begin
      if (n_pat >= 300) break;
      @(negedge clk);
    end
    mode = 2'b11;
    wait_drain("t5");
    check("t5_wrap", 32'(n_pat > 256), 32'd1);
    check("t5_bcnt", 32'(bcnt), 32'(hs % 16));
    pat_chk = 1'b0;

    // Reset while a request is outstanding and the FIFO holds bytes.
    ack_en = 1'b0; mode = 2'b00;
    for (int i = 0; i < 4; i++) core_cycle(1'b1, DW'($urandom), took);
    core_cycle(1'b0, 8'h00, took);
    repeat (2) @(negedge clk);
    check("t6_req_pre", 32'(bus.pmod_req_o), 32'd1);
    check("t6_lvl_pre", 32'(level), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_req", 32'(bus.pmod_req_o), 32'd0);
    check("t6_level", 32'(level), 32'd0);
    check("t6_ovf", 32'(ovf), 32'd0);
    check("t6_bcnt", 32'(bcnt), 32'd0);
    exp_q.delete();
    hs = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ack_dly = 1; ack_en = 1'b1;
    core_cycle(1'b1, DW'($urandom), took);
    core_cycle(1'b1, DW'($urandom), took);
    core_cycle(1'b0, 8'h00, took);
    wait_drain("t6");
    check("t6_bcnt_after", 32'(bcnt), 32'(hs % 16));
    check("t6_hs", 32'(hs), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
